trim_frame_seq: RTL and testbench
=================================

TRIM_FRAME_SEQ -- requirements
Module: trim_frame_seq

Interface
REQ-001 Parameters (name, default, meaning):
- IMG_W, 256, pixels per row
- IMG_H, 256, rows per frame
- FLT_LAT, 2, filter latency in clk cycles, from P sampled to out valid; range 1..15
- AW, 16, address width; 2^AW >= IMG_W*IMG_H
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one frame; sampled in IDLE only
- abort  in  1  terminate current frame
- rd_addr  out  AW  source frame memory read address
- rd_data  in  8  source pixel; synchronous read, valid 1 cycle after rd_addr
- P  out  8  pixel to trimmed filter input
- p_valid  out  1  P carries a frame pixel
- flt_out  in  8  trimmed filter output
- wr_en  out  1  result memory write strobe
- wr_addr  out  AW  result memory write address
- wr_data  out  8  result pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion or abort

Function
REQ-003 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE -> RUN on start=1; start in any other state is ignored.
REQ-005 RUN: rd_addr increments by 1 per cycle from 0 to N-1 (N = IMG_W*IMG_H); cycle after rd_addr=N-1 issues -> DRAIN.
REQ-006 P and p_valid are registered: the pixel addressed at cycle t appears on P, with p_valid=1, at cycle t+2.
REQ-007 Pixel at address a is written back: wr_en=1, wr_addr=a, wr_data=flt_out at cycle t+2+FLT_LAT; depth D = 2+FLT_LAT.
REQ-008 Write address comes from its own counter, advanced only on wr_en; it is never derived from rd_addr arithmetic.
REQ-009 DRAIN lasts until the write with wr_addr=N-1 completes, then -> DONE.
REQ-010 DONE lasts one cycle with done=1, then -> IDLE; total start-to-done = N+D+1 cycles.
REQ-011 busy=1 in RUN and DRAIN, else 0.
REQ-012 Valid pipeline is a D-deep shift register of valid bits; wr_en is its tail.
REQ-013 Address counters saturate at N-1; no wrap past the frame; N = 2^AW is legal (full 65536-pixel frame).
REQ-014 abort=1 in RUN or DRAIN: valid pipeline cleared next cycle, no further wr_en, -> DONE (done pulse), then IDLE.
REQ-015 abort in IDLE or DONE is ignored; abort and start together in IDLE: start is ignored.
REQ-016 P holds its last value when p_valid=0; wr_data equals flt_out and matters only when wr_en=1.

Reset
REQ-017 rst=1 forces IDLE asynchronously; rd_addr=0, wr_addr=0, P=0, p_valid=0, wr_en=0, wr_data=0, busy=0, done=0, valid pipeline all 0.
REQ-018 Reset mid-frame abandons the frame with no done pulse; the next start after release begins at address 0.

Structure
REQ-019 Shared package holds the FSM state enum, the default IMG_W/IMG_H/FLT_LAT constants and the 8-bit pixel type.
REQ-020 One sub-module, trim_valid_pipe (parameterised-depth valid/address delay line), is natural; counters and FSM stay in the top level.

Verification
REQ-021 IMG_W=IMG_H=4, FLT_LAT=2, mem[a]=a, filter model = 2-cycle delay: start -> 16 writes, wr_addr 0..15, wr_data=a; done exactly 21 cycles after start sampled.
REQ-022 Same setup, abort asserted at the 6th RUN cycle -> no wr_en after the next cycle, one done pulse, busy=0; a following start rewrites addresses 0..15.
REQ-023 rst pulsed during DRAIN -> all outputs 0 immediately, no done; a following start completes normally.
REQ-024 start held high continuously -> frames run back to back, each separated by exactly one IDLE cycle; start pulses during RUN are ignored.
REQ-025 Defaults (256x256, FLT_LAT=2) -> 65536 writes, last wr_addr=16'hFFFF, no address wrap, done after 65541 cycles.
REQ-026 FLT_LAT=1 and FLT_LAT=15 -> wr_en lags p_valid by exactly FLT_LAT cycles, for every pixel.

Source files
------------

// File: rtl/trim_frame_seq_pkg.sv
// Shared types and default frame geometry for the trim-filter frame sequencer.
package trim_frame_seq_pkg;

    localparam int IMG_W_DEF   = 256;
    localparam int IMG_H_DEF   = 256;
    localparam int FLT_LAT_DEF = 2;
    localparam int AW_DEF      = 16;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/trim_frame_seq_valid_pipe.sv
// Valid-bit delay line that follows each issued read address through the
// memory read, the P register and the filter. Stage 0 marks rd_data as
// valid, stage 1 marks P as valid, and the last stage is the write strobe.
module trim_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic q_rd,
    output logic q_pix,
    output logic q_wr
);

    logic [DEPTH-1:0] taps;

    // Shift the valid bits one stage per cycle; clr flushes pixels still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else if (clr) begin
            taps <= '0;
        end else begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

    assign q_rd  = taps[0];
    assign q_pix = taps[1];
    assign q_wr  = taps[DEPTH-1];

endmodule

// File: rtl/trim_frame_seq.sv
// Frame sequencer: streams one frame from source memory through the trimmed
// filter and writes the results back, with abort and back-to-back starts.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; counters held at 0
// ST_RUN   | issuing read addresses 0..N-1, one per cycle
// ST_DRAIN | all reads issued; waiting for the write of pixel N-1
// ST_DONE  | one-cycle done pulse, then back to idle
module trim_frame_seq
    import trim_frame_seq_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int FLT_LAT = FLT_LAT_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    P,
    output logic          p_valid,
    input  logic [7:0]    flt_out,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          done
);

    localparam int          N    = IMG_W * IMG_H;
    localparam int          D    = 2 + FLT_LAT;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t state, state_nx;
    pix_t   pix_q;
    logic   issue;
    logic   kill;
    logic   rd_ok;

    assign issue = (state == ST_RUN);
    assign kill  = abort && ((state == ST_RUN) || (state == ST_DRAIN));

    trim_valid_pipe #(
        .DEPTH (D)
    ) u_vpipe (
        .clk   (clk),
        .rst   (rst),
        .clr   (kill),
        .din   (issue),
        .q_rd  (rd_ok),
        .q_pix (p_valid),
        .q_wr  (wr_en)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_nx = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort)                 state_nx = ST_DONE;
                else if (rd_addr == LAST)  state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (abort || (wr_en && wr_addr == LAST)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read address: counts through the frame in RUN, saturating at the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
        end else begin
            case (state)
                ST_RUN:   if (rd_addr != LAST) rd_addr <= rd_addr + 1'b1;
                ST_DRAIN: rd_addr <= rd_addr;
                default:  rd_addr <= '0;
            endcase
        end
    end

    // Write address: independent counter stepped only by completed writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
        end else if ((state == ST_IDLE) || (state == ST_DONE)) begin
            wr_addr <= '0;
        end else if (wr_en && (wr_addr != LAST)) begin
            wr_addr <= wr_addr + 1'b1;
        end
    end

    // Capture the source pixel one cycle after its read; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pix_q <= '0;
        else if (rd_ok) pix_q <= rd_data;
    end

    assign P       = pix_q;
    assign wr_data = wr_en ? flt_out : 8'h00;

endmodule

// File: tb/tb_trim_frame_seq.sv
// Directed-random bench for trim_frame_seq: a 4x4 instance exercises frames,
// aborts, resets and back-to-back starts; three side instances cover filter
// latencies 1 and 15 and the full default 256x256 frame.
module tb_trim_frame_seq;

    localparam int N  = 16;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- main 4x4 instance ----------------
    logic       rst, start, abort;
    logic [3:0] rd_addr, wr_addr;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] P, flt_out, wr_data;
    logic       p_valid, wr_en, busy, done;
    logic [7:0] mem [16];
    logic [7:0] fd1 = 8'h00, fd2 = 8'h00;

    trim_frame_seq #(.IMG_W(4), .IMG_H(4), .FLT_LAT(2), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .P(P), .p_valid(p_valid),
        .flt_out(flt_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done));

    always @(posedge clk) rd_data <= mem[rd_addr];
    always @(posedge clk) begin
        fd1 <= P;
        fd2 <= fd1;
    end
    assign flt_out = fd2;

    typedef struct {int cyc; int addr; int data;} wr_t;
    wr_t wq[$];
    int  dq[$];

    always @(negedge clk) begin
        if (wr_en) wq.push_back('{cyc, int'(wr_addr), int'(wr_data)});
        if (done)  dq.push_back(cyc);
    end

    // ---------------- side instances (own reset and start) ----------------
    logic rst_aux, aux_start;

    // A: 2x2 frame, AW=2 (N = 2^AW), FLT_LAT=15
    logic [1:0] a_rd_addr, a_wr_addr;
    logic [7:0] a_rd_data = 8'h00, a_P, a_wr_data;
    logic       a_p_valid, a_wr_en, a_busy, a_done;
    trim_frame_seq #(.IMG_W(2), .IMG_H(2), .FLT_LAT(15), .AW(2)) dut_a (
        .clk(clk), .rst(rst_aux), .start(aux_start), .abort(1'b0),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .P(a_P), .p_valid(a_p_valid),
        .flt_out(a_P), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done));
    always @(posedge clk) a_rd_data <= {6'd0, a_rd_addr};

    // B: 4x2 frame, AW=3 (N = 2^AW), FLT_LAT=1
    logic [2:0] b_rd_addr, b_wr_addr;
    logic [7:0] b_rd_data = 8'h00, b_P, b_wr_data;
    logic       b_p_valid, b_wr_en, b_busy, b_done;
    trim_frame_seq #(.IMG_W(4), .IMG_H(2), .FLT_LAT(1), .AW(3)) dut_b (
        .clk(clk), .rst(rst_aux), .start(aux_start), .abort(1'b0),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .P(b_P), .p_valid(b_p_valid),
        .flt_out(b_P), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done));
    always @(posedge clk) b_rd_data <= {5'd0, b_rd_addr};

    // F: default parameters, full 65536-pixel frame
    logic [15:0] f_rd_addr, f_wr_addr;
    logic [7:0]  f_rd_data = 8'h00, f_P, f_wr_data;
    logic        f_p_valid, f_wr_en, f_busy, f_done;
    trim_frame_seq dut_f (
        .clk(clk), .rst(rst_aux), .start(aux_start), .abort(1'b0),
        .rd_addr(f_rd_addr), .rd_data(f_rd_data), .P(f_P), .p_valid(f_p_valid),
        .flt_out(f_P), .wr_en(f_wr_en), .wr_addr(f_wr_addr), .wr_data(f_wr_data),
        .busy(f_busy), .done(f_done));
    always @(posedge clk) f_rd_data <= f_rd_addr[7:0];

    int a_pv[$], a_we[$], a_wa[$], a_dn[$];
    int b_pv[$], b_we[$], b_wa[$], b_dn[$];
    int f_cnt = 0, f_last = -1, f_seq_err = 0, f_done_cyc = -1;

    always @(negedge clk) begin
        if (a_p_valid) a_pv.push_back(cyc);
        if (a_wr_en) begin a_we.push_back(cyc); a_wa.push_back(int'(a_wr_addr)); end
        if (a_done)  a_dn.push_back(cyc);
        if (b_p_valid) b_pv.push_back(cyc);
        if (b_wr_en) begin b_we.push_back(cyc); b_wa.push_back(int'(b_wr_addr)); end
        if (b_done)  b_dn.push_back(cyc);
        if (f_wr_en) begin
            if (int'(f_wr_addr) != f_cnt) f_seq_err++;
            f_last = int'(f_wr_addr);
            f_cnt++;
        end
        if (f_done && f_done_cyc < 0) f_done_cyc = cyc;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_P"},       32'(P), 0);
        chk({tag, "_p_valid"}, 32'(p_valid), 0);
        chk({tag, "_wr_en"},   32'(wr_en), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_done"},    32'(done), 0);
    endtask

    // Reference: frame k has its start sampled at sc + k*(N+D+2) (done, one idle
    // cycle, then the next start); pixel a of that frame is written at
    // sample+1+a+D with the memory word at a; done lands at sample+done_rel.
    task automatic check_run(input string tag, input int sc, input int nframes,
                             input int nwr, input int done_rel);
        int base;
        int a;
        chk({tag, "_wr_count"}, 32'(wq.size()), 32'(nframes * nwr));
        for (int i = 0; i < wq.size() && i < nframes * nwr; i++) begin
            a    = i % nwr;
            base = sc + (i / nwr) * (N + D + 2);
            chk({tag, "_wr_addr"}, 32'(wq[i].addr), 32'(a));
            chk({tag, "_wr_data"}, 32'(wq[i].data), 32'(mem[a]));
            chk({tag, "_wr_cycle"}, 32'(wq[i].cyc), 32'(base + 1 + a + D));
        end
        chk({tag, "_done_count"}, 32'(dq.size()), 32'(nframes));
        for (int k = 0; k < dq.size() && k < nframes; k++)
            chk({tag, "_done_cycle"}, 32'(dq[k]), 32'(sc + k * (N + D + 2) + done_rel));
        chk({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    task automatic new_frame_data();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        wq.delete();
        dq.delete();
    endtask

    task automatic start_pulse(output int sc);
        @(negedge clk);
        sc    = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int sc, asc, ka, nwr;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        rst_aux = 1'b1; aux_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        @(negedge clk);
        rst = 1'b0; rst_aux = 1'b0;
        @(negedge clk);
        asc = cyc;
        aux_start = 1'b1;
        @(negedge clk);
        aux_start = 1'b0;

        // Plain frame with mem[a]=a, then with random contents.
        wq.delete(); dq.delete();
        start_pulse(sc);
        repeat (30) @(negedge clk);
        check_run("frame_ident", sc, 1, N, N + D + 1);

        new_frame_data();
        start_pulse(sc);
        repeat (30) @(negedge clk);
        check_run("frame_rand", sc, 1, N, N + D + 1);

        // Extra start pulses while RUN is active must be ignored.
        new_frame_data();
        start_pulse(sc);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_run("start_in_run", sc, 1, N, N + D + 1);

        // Abort and start together in IDLE: nothing happens. Abort alone too.
        wq.delete(); dq.delete();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_start_abort_busy", 32'(busy), 0);
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_abort_done_count", 32'(dq.size()), 0);
        chk("idle_abort_wr_count", 32'(wq.size()), 0);

        // Abort on the 6th RUN cycle (RUN index 5), then random abort points.
        for (int r = 0; r < 4; r++) begin
            new_frame_data();
            ka = (r == 0) ? 5 : int'($urandom_range(0, N + D - 1));
            start_pulse(sc);
            while (cyc < sc + 1 + ka) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (25) @(negedge clk);
            nwr = ka - D + 1;
            if (nwr < 0) nwr = 0;
            if (nwr > N) nwr = N;
            chk("abort_wr_count", 32'(wq.size()), 32'(nwr));
            for (int i = 0; i < wq.size() && i < nwr; i++) begin
                chk("abort_wr_addr", 32'(wq[i].addr), 32'(i));
                chk("abort_wr_cycle", 32'(wq[i].cyc), 32'(sc + 1 + i + D));
            end
            chk("abort_done_count", 32'(dq.size()), 1);
            if (dq.size() > 0) chk("abort_done_cycle", 32'(dq[0]), 32'(sc + ka + 2));
            chk("abort_busy", 32'(busy), 0);
        end

        new_frame_data();
        start_pulse(sc);
        repeat (30) @(negedge clk);
        check_run("after_abort", sc, 1, N, N + D + 1);

        // Reset in DRAIN: outputs drop at once, no done; next frame is normal.
        new_frame_data();
        start_pulse(sc);
        while (cyc < sc + 1 + N + 1) @(negedge clk);
        chk("drain_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_drain");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_drain_done_count", 32'(dq.size()), 0);
        new_frame_data();
        start_pulse(sc);
        repeat (30) @(negedge clk);
        check_run("after_rst", sc, 1, N, N + D + 1);

        // Start held high: two frames back to back with one IDLE cycle between.
        new_frame_data();
        @(negedge clk);
        sc    = cyc;
        start = 1'b1;
        while (cyc < sc + 40) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check_run("start_held", sc, 2, N, N + D + 1);

        // Side instances: latency 15 and 1, full default frame.
        chk("lat15_pv_count", 32'(a_pv.size()), 4);
        chk("lat15_we_count", 32'(a_we.size()), 4);
        for (int i = 0; i < a_we.size() && i < a_pv.size(); i++) begin
            chk("lat15_lag", 32'(a_we[i] - a_pv[i]), 15);
            chk("lat15_wr_addr", 32'(a_wa[i]), 32'(i));
        end
        chk("lat15_done_count", 32'(a_dn.size()), 1);
        if (a_dn.size() > 0) chk("lat15_done_cycle", 32'(a_dn[0]), 32'(asc + 4 + 17 + 1));

        chk("lat1_pv_count", 32'(b_pv.size()), 8);
        chk("lat1_we_count", 32'(b_we.size()), 8);
        for (int i = 0; i < b_we.size() && i < b_pv.size(); i++) begin
            chk("lat1_lag", 32'(b_we[i] - b_pv[i]), 1);
            chk("lat1_wr_addr", 32'(b_wa[i]), 32'(i));
        end
        chk("lat1_done_count", 32'(b_dn.size()), 1);
        if (b_dn.size() > 0) chk("lat1_done_cycle", 32'(b_dn[0]), 32'(asc + 8 + 3 + 1));

        while (f_done_cyc < 0 && cyc < asc + 65600) @(negedge clk);
        chk("full_wr_count", 32'(f_cnt), 65536);
        chk("full_last_addr", 32'(f_last), 32'h0000_FFFF);
        chk("full_addr_order_errs", 32'(f_seq_err), 0);
        chk("full_done_cycle", 32'(f_done_cyc), 32'(asc + 65541));
        repeat (2) @(negedge clk);
        chk("full_busy_end", 32'(f_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
